// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a multiplexed, active-low 7-segment display bus.
// It waits for each digit's dwell to settle, decodes the segment pattern into a
// 4-bit code and publishes a full frame once every digit has been captured.
// Optional feature: define SEG_ERR_CNT_EN to add the saturating err_count output.
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic                    stale
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    // Registered copies of the bus, plus the previous sample for change detection
    logic [NUM_DIGITS-1:0]   an_q, an_d, an_prev_q, an_prev_d;
    logic [6:0]              seg_q, seg_d, seg_prev_q, seg_prev_d;

    // Dwell tracking, frame assembly and published outputs
    logic [SW-1:0]           stab_q, stab_d;
    logic                    armed_q, armed_d;
    logic [TW-1:0]           to_q, to_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    pattern_err_q, pattern_err_d;
    logic                    stale_q, stale_d;
`ifdef SEG_ERR_CNT_EN
    logic [7:0]              err_cnt_q, err_cnt_d;
`endif

    // Combinational helpers
    logic                    changed;
    logic [NUM_DIGITS-1:0]   an_low;
    logic                    one_hot;
    logic [IW-1:0]           cap_idx;
    logic                    capture;
    logic [3:0]              code;
    logic                    code_bad;
    logic                    publish;
    logic                    timeout;

    // Next-state logic: settle detection, decode, capture, publish and timeout
    always_comb begin
        an_d       = an;
        seg_d      = seg;
        an_prev_d  = an_q;
        seg_prev_d = seg_q;

        changed = ({an_q, seg_q} != {an_prev_q, seg_prev_q});

        an_low  = ~an_q;
        one_hot = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                cap_idx = IW'(i);
            end
        end

        code_bad = 1'b0;
        case (seg_q)
            7'b1000000: code = 4'h0;
            7'b1111001: code = 4'h1;
            7'b0100100: code = 4'h2;
            7'b0110000: code = 4'h3;
            7'b0011001: code = 4'h4;
            7'b0010010: code = 4'h5;
            7'b0000010: code = 4'h6;
            7'b1111000: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0010000: code = 4'h9;
            7'b0111111: code = 4'hF;
            7'b1111111: code = 4'hE;
            default: begin
                code     = 4'hD;
                code_bad = 1'b1;
            end
        endcase

        if (changed) begin
            stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + SW'(1);
        end

        capture = !changed && armed_q && (stab_d == STAB_MAX) && one_hot;

        if (changed) begin
            armed_d = 1'b1;
        end else if (capture) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end

        timeout = (to_q == TO_MAX);
        if (capture) begin
            to_d = '0;
        end else if (timeout) begin
            to_d = to_q;
        end else begin
            to_d = to_q + TW'(1);
        end

        publish = &mask_q;

        mask_d = mask_q;
        if (publish || timeout) begin
            mask_d = '0;
        end
        shadow_d = shadow_q;
        if (capture) begin
            mask_d[cap_idx]                   = 1'b1;
            shadow_d[int'(cap_idx) * 4 +: 4]  = code;
        end

        digits_d      = publish ? shadow_q : digits_q;
        frame_valid_d = publish;
        pattern_err_d = capture && code_bad;

        if (publish) begin
            stale_d = 1'b0;
        end else if (timeout) begin
            stale_d = 1'b1;
        end else begin
            stale_d = stale_q;
        end

`ifdef SEG_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
        if (pattern_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
`endif
    end

    // State registers; an idle (all-high) bus is the reset image of the input stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q          <= '1;
            seg_q         <= '1;
            an_prev_q     <= '1;
            seg_prev_q    <= '1;
            stab_q        <= '0;
            armed_q       <= 1'b0;
            to_q          <= '0;
            mask_q        <= '0;
            shadow_q      <= '0;
            digits_q      <= '0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
            stale_q       <= 1'b1;
`ifdef SEG_ERR_CNT_EN
            err_cnt_q     <= 8'd0;
`endif
        end else begin
            an_q          <= an_d;
            seg_q         <= seg_d;
            an_prev_q     <= an_prev_d;
            seg_prev_q    <= seg_prev_d;
            stab_q        <= stab_d;
            armed_q       <= armed_d;
            to_q          <= to_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
            stale_q       <= stale_d;
`ifdef SEG_ERR_CNT_EN
            err_cnt_q     <= err_cnt_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign pattern_err = pattern_err_q;
    assign stale       = stale_q;
`ifdef SEG_ERR_CNT_EN
    assign err_count   = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: drives dwells on the scanned display bus and compares
// published frames, error pulses and staleness against a dwell-level model.
module tb_seg_scan_decoder;

    localparam int N = 4;
    localparam int S = 16;
    localparam int T = 256;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic [4*N-1:0] digits;
    logic           frame_valid;
    logic           pattern_err;
    logic           stale;
`ifdef SEG_ERR_CNT_EN
    logic [7:0]     err_count;
`endif

    seg_scan_decoder #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .seg        (seg),
        .digits     (digits),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err),
        .stale      (stale)
`ifdef SEG_ERR_CNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Segment images of 0..9 on the active-low {g..a} bus
    logic [6:0] segTab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Observed activity, collected at the falling edge
    logic [4*N-1:0] obsDigits[$];
    int unsigned    obsCyc[$];
    int             obsErr = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) begin
                obsDigits.push_back(digits);
                obsCyc.push_back(cyc);
            end
            if (pattern_err) obsErr++;
        end
    end

    // Dwell-level reference model
    logic [3:0]     mShadow [N];
    logic [N-1:0]   mMask;
    logic           mStale;
    logic [4*N-1:0] mDigits;
    int             mErrCnt;
    int             expErr = 0;
    logic [4*N-1:0] expDigits[$];
    int unsigned    expCyc[$];
    logic [N-1:0]   prevAn;
    logic [6:0]     prevSeg;
    int unsigned    runStart;
    int             runLen;
    bit             runCaptured;
    int             gap;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [4:0] decodeModel(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (segTab[d] == s) return {1'b0, 4'(d)};
        end
        if (s == 7'b0111111) return {1'b0, 4'hF};
        if (s == 7'b1111111) return {1'b0, 4'hE};
        return {1'b1, 4'hD};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) mShadow[i] = 4'h0;
        mMask       = '0;
        mStale      = 1'b1;
        mDigits     = '0;
        mErrCnt     = 0;
        prevAn      = '1;
        prevSeg     = 7'h7F;
        runStart    = cyc;
        runLen      = 0;
        runCaptured = 1'b0;
        gap         = 0;
    endtask

    task automatic modelCapture(input logic [N-1:0] a, input logic [6:0] s);
        logic [4:0] dec;
        int idx;
        dec = decodeModel(s);
        idx = 0;
        for (int i = 0; i < N; i++) if (!a[i]) idx = i;
        if (dec[4]) begin
            expErr++;
            if (mErrCnt < 255) mErrCnt++;
        end
        mShadow[idx] = dec[3:0];
        mMask[idx]   = 1'b1;
        if (&mMask) begin
            for (int i = 0; i < N; i++) mDigits[4*i +: 4] = mShadow[i];
            expDigits.push_back(mDigits);
            expCyc.push_back(runStart + S + 2);
            mMask  = '0;
            mStale = 1'b0;
        end
    endtask

    // Hold one bus value for len cycles; identical consecutive values form one dwell
    task automatic applyStimulus(input logic [N-1:0] a, input logic [6:0] s, input int len);
        int oldLen;
        an  = a;
        seg = s;
        if (a != prevAn || s != prevSeg) begin
            prevAn      = a;
            prevSeg     = s;
            runStart    = cyc;
            runLen      = 0;
            runCaptured = 1'b0;
        end
        oldLen = runLen;
        runLen += len;
        if ($countones(~a) == 1 && !runCaptured && runLen >= S) begin
            gap += S - oldLen;
            if (gap >= T + 4) begin
                mMask  = '0;
                mStale = 1'b1;
            end
            modelCapture(a, s);
            runCaptured = 1'b1;
            gap = runLen - S;
        end else begin
            gap += len;
            if (gap >= T + 4) begin
                mMask  = '0;
                mStale = 1'b1;
            end
        end
        repeat (len) @(negedge clk);
    endtask

    task automatic showDigit(input int pos, input logic [6:0] s, input int len);
        applyStimulus(~(N'(1) << pos), s, len);
    endtask

    task automatic flushAndCheck(input string tag);
        int n;
        applyStimulus('1, 7'h7F, 6);
        checkOutput({tag, ".frames"}, obsDigits.size(), expDigits.size());
        n = (obsDigits.size() < expDigits.size()) ? obsDigits.size() : expDigits.size();
        for (int k = 0; k < n; k++) begin
            checkOutput({tag, ".frameDigits"}, obsDigits[k], expDigits[k]);
            checkOutput({tag, ".frameCycle"}, obsCyc[k], expCyc[k]);
        end
        checkOutput({tag, ".patternErr"}, obsErr, expErr);
        checkOutput({tag, ".stale"}, stale, mStale);
        checkOutput({tag, ".digits"}, digits, mDigits);
`ifdef SEG_ERR_CNT_EN
        checkOutput({tag, ".errCount"}, err_count, mErrCnt);
`endif
        obsDigits.delete();
        obsCyc.delete();
        expDigits.delete();
        expCyc.delete();
    endtask

    initial begin
        reset = 1'b1;
        an    = '1;
        seg   = 7'h7F;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("rst.digits", digits, 0);
        checkOutput("rst.stale", stale, 1);

        // T1: reset in the middle of a dwell on digit 0
        showDigit(0, segTab[1], 20);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t1.digits", digits, 0);
        checkOutput("t1.frameValid", frame_valid, 0);
        checkOutput("t1.stale", stale, 1);
        reset = 1'b0;
        modelReset();
        flushAndCheck("t1");

        // T2: scan "1234"
        for (int i = 0; i < N; i++) showDigit(i, segTab[i+1], 64);
        flushAndCheck("t2");
        checkOutput("t2.value", digits, 16'h4321);

        // T3: short dwells on digit 2 around the settle threshold
        showDigit(0, segTab[5], 20);
        showDigit(1, segTab[6], 20);
        showDigit(2, segTab[7], 10);
        showDigit(3, segTab[8], 20);
        flushAndCheck("t3a");
        showDigit(2, segTab[7], S - 1);
        flushAndCheck("t3b");
        showDigit(2, segTab[7], S);
        flushAndCheck("t3c");

        // T4: dash, blank and an undecodable pattern
        showDigit(0, 7'b0111111, 20);
        showDigit(1, 7'b1111111, 20);
        showDigit(2, 7'b0001000, 20);
        showDigit(3, segTab[9], 20);
        flushAndCheck("t4");
        checkOutput("t4.nibbles", digits[11:0], 12'hDEF);

        // T5: invalid anode patterns do not capture and keep the mask
        showDigit(0, segTab[2], 20);
        showDigit(1, segTab[3], 20);
        applyStimulus(4'b0101, segTab[4], 100);
        applyStimulus(4'b1111, segTab[4], 60);
        showDigit(2, segTab[0], 20);
        showDigit(3, segTab[1], 20);
        flushAndCheck("t5");

        // T6: scanning stops, frame goes stale, a partial frame is dropped
        applyStimulus('1, 7'h7F, T + 100);
        flushAndCheck("t6a");
        showDigit(0, segTab[3], 20);
        showDigit(1, segTab[4], 20);
        applyStimulus('1, 7'h7F, T + 100);
        showDigit(2, segTab[5], 20);
        showDigit(3, segTab[6], 20);
        flushAndCheck("t6b");
        showDigit(0, segTab[7], 20);
        showDigit(1, segTab[8], 20);
        flushAndCheck("t6c");

        // Reset in the middle of a frame drops the captured digits
        showDigit(2, segTab[1], 20);
        showDigit(3, segTab[2], 20);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
        showDigit(0, segTab[3], 20);
        showDigit(1, segTab[4], 20);
        flushAndCheck("rstMid");

        // Randomized scanning with glitches and noise dwells
        for (int g = 0; g < 60; g++) begin
            int nNoise;
            logic [N-1:0] a;
            logic [6:0]   s;
            nNoise = $urandom_range(0, 3);
            for (int k = 0; k < nNoise; k++) begin
                if ($urandom_range(0, 1) == 0) a = N'($urandom_range(0, 15));
                else                           a = ~(N'(1) << $urandom_range(0, N - 1));
                if ($urandom_range(0, 9) < 7) s = segTab[$urandom_range(0, 9)];
                else                          s = 7'($urandom_range(0, 127));
                applyStimulus(a, s, $urandom_range(1, 20));
            end
            if ($urandom_range(0, 9) < 8) s = segTab[$urandom_range(0, 9)];
            else                          s = 7'($urandom_range(0, 127));
            showDigit(g % N, s, $urandom_range(S, 40));
            if (g % 15 == 14) flushAndCheck("rand");
        end
        flushAndCheck("randEnd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
